// File: rtl/resp_pkg.sv
// Shared definitions for the response serializer:
// entry layout constants and FSM state encoding.
package resp_pkg;

  localparam int ENTRY_W = 65;
  localparam int ERR_BIT = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    CAPT = 2'd2,
    SEND = 2'd3
  } state_t;

endpackage

// File: rtl/response_serializer.sv
// Pops 65-bit response entries and streams the payload as host beats.
// Optional macro RESP_SERIALIZER_PARITY_EN adds even parity output tx_par.
module response_serializer #(
  parameter int BEAT_W  = 16,
  parameter int ENTRY_W = resp_pkg::ENTRY_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               buf_nempty,
  input  logic [ENTRY_W-1:0] buf_data,
  input  logic               buf_wen_mon,
  output logic               buf_read,
  input  logic               tx_ready,
  output logic               tx_valid,
  output logic [BEAT_W-1:0]  tx_data,
  output logic               tx_first,
  output logic               tx_last,
  output logic               tx_err,
  output logic               busy
`ifdef RESP_SERIALIZER_PARITY_EN
  ,
  output logic               tx_par
`endif
);

  import resp_pkg::state_t;
  import resp_pkg::IDLE;
  import resp_pkg::READ;
  import resp_pkg::CAPT;
  import resp_pkg::SEND;
  import resp_pkg::ERR_BIT;

  localparam int NBEATS = 64 / BEAT_W;
  localparam int CNT_W  = $clog2(NBEATS) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBEATS - 1);

  state_t             state;
  state_t             nxt;
  logic [63:0]        shreg;
  logic [63:0]        shnext;
  logic               err;
  logic [CNT_W-1:0]   cnt;
  logic               last;
  logic               send;
  logic               adv;

  assign send   = state == SEND;
  assign last   = cnt == LAST_CNT;
  assign adv    = send && tx_ready && !last;
  assign shnext = shreg >> BEAT_W;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // A write in the same cycle as our pop wins in the buffer,
  // so READ repeats until the pop goes through.
  always_comb begin
    nxt      = state;
    buf_read = 1'b0;
    tx_valid = 1'b0;
    unique case (state)
      IDLE: if (buf_nempty) nxt = READ;
      READ: begin
        buf_read = 1'b1;
        if (!buf_wen_mon) nxt = CAPT;
      end
      CAPT: nxt = SEND;
      SEND: begin
        tx_valid = 1'b1;
        if (tx_ready && last)
          nxt = buf_nempty ? READ : IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg <= '0;
      err   <= 1'b0;
      cnt   <= '0;
    end else if (state == CAPT) begin
      shreg <= buf_data[63:0];
      err   <= buf_data[ERR_BIT];
      cnt   <= '0;
    end else if (adv) begin
      shreg <= shnext;
      cnt   <= cnt + CNT_W'(1);
    end
  end

  assign tx_data  = send ? shreg[BEAT_W-1:0] : '0;
  assign tx_first = send && (cnt == '0);
  assign tx_last  = send && last;
  assign tx_err   = send && err;
  assign busy     = state != IDLE;

`ifdef RESP_SERIALIZER_PARITY_EN
  logic par;

  always_ff @(posedge clk) begin
    if (reset)               par <= 1'b0;
    else if (state == CAPT)  par <= ^buf_data[BEAT_W-1:0];
    else if (adv)            par <= ^shnext[BEAT_W-1:0];
  end

  assign tx_par = send && par;
`endif

endmodule

// File: tb/tb_response_serializer.sv
// Scoreboard bench for response_serializer (BEAT_W=16) with a
// behavioural response buffer and directed entries.
module tb_response_serializer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        buf_nempty = 1'b0;
  logic [64:0] buf_data = '0;
  logic        buf_wen_mon = 1'b0;
  logic        buf_read;
  logic        tx_ready = 1'b1;
  logic        tx_valid;
  logic [15:0] tx_data;
  logic        tx_first;
  logic        tx_last;
  logic        tx_err;
  logic        busy;
`ifdef RESP_SERIALIZER_PARITY_EN
  logic        tx_par;
`endif

  response_serializer #(.BEAT_W(16), .ENTRY_W(65)) dut (
    .clk(clk),
    .reset(reset),
    .buf_nempty(buf_nempty),
    .buf_data(buf_data),
    .buf_wen_mon(buf_wen_mon),
    .buf_read(buf_read),
    .tx_ready(tx_ready),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_first(tx_first),
    .tx_last(tx_last),
    .tx_err(tx_err),
    .busy(busy)
`ifdef RESP_SERIALIZER_PARITY_EN
    ,
    .tx_par(tx_par)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic        f;
    logic        l;
    logic        e;
    logic        p;
  } beat_t;

  logic [64:0] bq[$];
  beat_t       exp_q[$];
  int          firsts[$];
  int          lasts[$];
  int          reads[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          rd_pulses = 0;
  int          pops = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc++;

  // Buffer model: registered output, pop dropped on write collision
  always @(negedge clk) begin
    if (buf_read) begin
      rd_pulses++;
      reads.push_back(cyc);
      if (!buf_wen_mon && bq.size() != 0) begin
        buf_data = bq.pop_front();
        pops++;
      end
    end
    buf_nempty = bq.size() != 0;
  end

  always @(negedge clk) begin
    beat_t b;
    if (tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {48'd0, tx_data}, 64'hDEAD);
      end else begin
        b = exp_q.pop_front();
        chk("beat", {45'd0, tx_data, tx_first, tx_last, tx_err},
            {45'd0, b.d, b.f, b.l, b.e});
`ifdef RESP_SERIALIZER_PARITY_EN
        chk("parity", {63'd0, tx_par}, {63'd0, b.p});
`endif
      end
      if (tx_first) firsts.push_back(cyc);
      if (tx_last) lasts.push_back(cyc);
    end
  end

  task automatic push(input logic [64:0] e, input logic [15:0] b0,
                      input logic [15:0] b1, input logic [15:0] b2,
                      input logic [15:0] b3);
    logic [15:0] bs[4];
    bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3;
    for (int i = 0; i < 4; i++)
      exp_q.push_back('{bs[i], i == 0, i == 3, e[64], ^bs[i]});
    bq.push_back(e);
    buf_nempty = 1'b1;
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    forever begin
      @(negedge clk);
      if (tx_valid) break;
      k++;
      if (k > 50) begin
        chk("wait_valid_timeout", 64'd1, 64'd0);
        break;
      end
    end
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) break;
      k++;
      if (k > 200) begin
        chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k, rp0, pp0, n0, nv;
    logic found;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state",
        {42'd0, busy, tx_valid, buf_read, tx_first, tx_last, tx_err, tx_data},
        64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    // Basic entry, latency and back-to-back beats
    push(65'h0_1122_3344_5566_7788, 16'h7788, 16'h5566, 16'h3344, 16'h1122);
    wait_valid(k);
    chk("latency", 64'(k), 64'd3);
    wait_drain();
    chk("beats_consecutive", 64'(lasts[$] - firsts[$]), 64'd3);

    // Stalls: beat 0 held, then beat 1 held for 3 cycles
    tx_ready = 1'b0;
    push(65'h1_0000_0000_0000_00FF, 16'h00FF, 16'h0000, 16'h0000, 16'h0000);
    wait_valid(k);
    chk("hold_beat0", {46'd0, tx_first, tx_err, tx_data}, {46'd0, 2'b11, 16'h00FF});
    @(posedge clk);
    #1 tx_ready = 1'b1;
    @(posedge clk);
    #1 tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_beat1", {45'd0, tx_valid, tx_first, tx_err, tx_data},
          {45'd0, 3'b101, 16'h0000});
    end
    @(posedge clk);
    #1 tx_ready = 1'b1;
    wait_drain();

    // Write collision on first READ
    buf_wen_mon = 1'b1;
    rp0 = rd_pulses;
    pp0 = pops;
    push(65'h0_DEAD_BEEF_CAFE_F00D, 16'hF00D, 16'hCAFE, 16'hBEEF, 16'hDEAD);
    k = 0;
    while (!buf_read && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("read_seen", 64'(buf_read), 64'd1);
    @(posedge clk);
    #1 buf_wen_mon = 1'b0;
    wait_drain();
    chk("read_pulses", 64'(rd_pulses - rp0), 64'd2);
    chk("pops", 64'(pops - pp0), 64'd1);

    // Two queued entries, no IDLE bubble
    n0 = lasts.size();
    push(65'h0_0000_0000_7789_7788, 16'h7788, 16'h7789, 16'h0000, 16'h0000);
    push(65'h1_8000_0000_0000_0001, 16'h0001, 16'h0000, 16'h0000, 16'h8000);
    wait_drain();
    if (lasts.size() > n0 && firsts.size() > n0 + 1) begin
      chk("b2b_gap", 64'(firsts[n0 + 1] - lasts[n0]), 64'd3);
      found = 1'b0;
      foreach (reads[i]) if (reads[i] == lasts[n0] + 1) found = 1'b1;
      chk("read_after_last", 64'(found), 64'd1);
    end else begin
      chk("b2b_beats_seen", 64'(lasts.size()), 64'(n0 + 2));
    end

    // Reset during beat 2 discards the entry
    push(65'h0_4444_3333_2222_1111, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    wait_valid(k);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("beat2_present", {48'd0, tx_data}, {48'd0, 16'h3333});
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mid_reset",
        {42'd0, busy, tx_valid, buf_read, tx_first, tx_last, tx_err, tx_data},
        64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_valid || busy) nv++;
    end
    chk("no_replay", 64'(nv), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/response_serializer.md
RESPONSE_SERIALIZER -- requirements
Module: response_serializer

Interface
REQ-001 SHALL have parameter BEAT_W, default 16, host beat width; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter ENTRY_W, default 65, response entry width: bit 64 = error flag, bits 63:0 = payload.
REQ-003 SHALL have port clk  input  1  clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port buf_nempty  input  1  response buffer not-empty indication.
REQ-006 SHALL have port buf_data  input  ENTRY_W  response buffer registered output word.
REQ-007 SHALL have port buf_wen_mon  input  1  monitor of the response buffer write enable.
REQ-008 SHALL have port buf_read  output  1  one-cycle pop request to the response buffer.
REQ-009 SHALL have port tx_ready  input  1  host accepts current beat.
REQ-010 SHALL have port tx_valid  output  1  beat valid.
REQ-011 SHALL have port tx_data  output  BEAT_W  beat payload.
REQ-012 SHALL have port tx_first  output  1  first beat of entry.
REQ-013 SHALL have port tx_last  output  1  last beat of entry.
REQ-014 SHALL have port tx_err  output  1  entry error flag, held for all beats.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, READ, CAPT, SEND; NBEATS = 64/BEAT_W.
REQ-017 IDLE: buf_read=0, tx_valid=0; buf_nempty=1 -> READ.
REQ-018 READ: buf_read=1 for exactly this cycle; buf_wen_mon=0 -> CAPT; buf_wen_mon=1 (buffer gives write priority, pop dropped) -> stay in READ, retry next cycle.
REQ-019 CAPT: register buf_data[63:0] into shift register, buf_data[64] into err register, beat counter=0 -> SEND.
REQ-020 SEND: tx_valid=1, tx_data = shift register bits [BEAT_W-1:0]; beats emitted least-significant first.
REQ-021 tx_first=1 when counter=0; tx_last=1 when counter=NBEATS-1; both high together when NBEATS=1.
REQ-022 tx_valid=1 and tx_ready=0: tx_data, tx_first, tx_last, tx_err SHALL hold unchanged.
REQ-023 tx_valid=1 and tx_ready=1, not last: shift right by BEAT_W, counter+1.
REQ-024 Last beat accepted: buf_nempty=1 -> READ (no IDLE bubble); else -> IDLE.
REQ-025 Latency: buf_nempty rising in IDLE cycle N -> first tx_valid in cycle N+3 (no collision).
REQ-026 buf_read SHALL never be asserted outside READ; at most one successful pop per entry sent.
REQ-027 Counter width SHALL be clog2(NBEATS)+1 bits; no wrap inside an entry.

Reset
REQ-028 reset=1 SHALL force IDLE, buf_read=0, tx_valid=0, tx_first=0, tx_last=0, tx_err=0, tx_data=0, busy=0, counter=0 on next edge.
REQ-029 reset mid-entry SHALL discard the remaining beats; the popped entry is lost, no partial replay.
REQ-030 reset SHALL take priority over all other inputs.

Configuration
REQ-031 With macro RESP_SERIALIZER_PARITY_EN defined, SHALL add output tx_par (1 bit) = XOR of tx_data bits (even parity), registered and held with tx_data.
REQ-032 Without RESP_SERIALIZER_PARITY_EN, tx_par port and logic SHALL be absent; all other behaviour identical.

Structure
REQ-033 Shared package resp_pkg SHALL hold ENTRY_W, error-bit index 64, and FSM state encoding (IDLE=2'd0, READ=2'd1, CAPT=2'd2, SEND=2'd3).
REQ-034 Single flat module; no sub-module.

Verification
REQ-035 Entry 65'h0_1122_3344_5566_7788, tx_ready=1, BEAT_W=16 -> beats 7788, 5566, 3344, 1122 on consecutive cycles; tx_first on beat 0, tx_last on beat 3, tx_err=0.
REQ-036 Entry 65'h1_0000_0000_0000_00FF, tx_ready low 3 cycles on beat 1 -> tx_data holds 16'h0000 for 4 cycles, tx_err=1 on all 4 beats.
REQ-037 buf_wen_mon=1 during first READ cycle -> buf_read pulses twice, exactly one entry serialized.
REQ-038 Two entries queued, tx_ready=1 -> READ follows last beat of entry 1 directly; entry 2 first beat 3 cycles after entry 1 last beat.
REQ-039 reset asserted during beat 2 -> next cycle tx_valid=0, busy=0, state IDLE.
REQ-040 RESP_SERIALIZER_PARITY_EN defined, beat 16'h7788 -> tx_par=0; beat 16'h7789 -> tx_par=1.
